muskbus_read_arbiter: RTL and testbench
=======================================

// Module: muskbus_read_arbiter
// PURPOSE
//  Shares one Muskbus cache-line reader (64B line, 512 bits) between NREQ clients,
//  e.g. instruction fetch and data load.
//  Round-robin, one transaction in flight, grant held from issue to line return.
//  Sits between the clients and the reader; the reader alone bids on Muskbus.
// PARAMETERS
//  NREQ     2     number of requesting clients (>=2)
//  TIMEOUT  4096  WAIT-state cycle limit before err_timeout; 0 disables the check
// PORTS
//  clk          in   1          clock
//  reset        in   1          synchronous, active-high reset
//  cl_reqcyc    in   NREQ       per-client request; held high until that client's cl_respcyc
//  cl_addr      in   NREQ*64    per-client line address; client i uses bits [i*64 +: 64]
//  cl_respcyc   out  NREQ       one-cycle pulse to the granted client: line valid on cl_data
//  cl_data      out  512        line data, broadcast to all clients; valid only with cl_respcyc
//  rd_reqcyc    out  1          start pulse to the reader
//  rd_addr      out  64         address to the reader; reader drives it combinationally onto the bus
//  rd_respcyc   in   1          reader line-complete pulse, one cycle
//  rd_data      in   512        reader line data, valid with rd_respcyc
//  grant_id     out  $clog2(NREQ)  index of the current or most recent grantee
//  busy         out  1          high in any state other than IDLE
//  err_timeout  out  1          sticky: WAIT exceeded TIMEOUT cycles
// BEHAVIOUR
//  Reset values: state IDLE, rr_ptr 0, grant_id 0, addr_ff 0, wait_cnt 0, err_timeout 0.
//  All outputs are 0 during and after reset.
//  State machine (registered): IDLE -> ISSUE -> WAIT -> COOL -> IDLE.
//  IDLE:
//   - If any cl_reqcyc is high, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod NREQ.
//   - Latch its index into grant_id and its cl_addr into addr_ff; go to ISSUE.
//   - If no request is pending, stay in IDLE.
//  ISSUE:
//   - rd_reqcyc = 1 for exactly this one cycle; clear wait_cnt; go to WAIT.
//  WAIT:
//   - rd_reqcyc = 0; wait_cnt increments and saturates.
//   - When rd_respcyc is high: cl_respcyc[grant_id] = 1 and cl_data = rd_data combinationally,
//     in the same cycle (no added latency).
//   - On that cycle: rr_ptr <= (grant_id+1) mod NREQ; go to COOL.
//  COOL:
//   - One idle cycle. Lets the served client drop cl_reqcyc and lets the reader return to idle,
//     so the reader never sees reqcyc in its final reading cycle.
//   - Go to IDLE.
//  rd_addr = addr_ff. It is stable from ISSUE through WAIT and does not change when
//   cl_addr changes after the grant.
//  cl_data = 0 whenever rd_respcyc is low or the state is not WAIT.
//   cl_respcyc is never asserted outside WAIT.
//  Latency: request in cycle t with the arbiter in IDLE gives rd_reqcyc in t+1.
//   The minimum spacing between the starts of back-to-back grants is reader time + 3 cycles.
//  Fairness: after serving client i, client i has the lowest priority.
//   With all clients requesting, each client waits at most NREQ-1 transactions.
//  Requests that change after the IDLE decision are ignored until the next IDLE.
//   A client dropping cl_reqcyc mid-grant does not abort the grant; the line is still
//   delivered via cl_respcyc.
//  err_timeout:
//   - Set when wait_cnt reaches TIMEOUT in WAIT (when TIMEOUT != 0); cleared only by reset.
//   - The FSM keeps waiting; there is no abort.
//  Reset mid-operation returns the FSM to IDLE immediately.
//   The reader shares the same reset, so no half transaction survives.
//  rd_respcyc outside WAIT is ignored: no cl_respcyc, no state change.
// TESTING
//  1. Client 0 only, addr 0x1000, reader returns after 20 cycles:
//     rd_reqcyc one pulse at t+1 with rd_addr=0x1000; cl_respcyc=01 with rd_data passed through.
//  2. Both clients request in the same cycle from reset:
//     client 0 served first, then client 1; grant_id 0 then 1.
//  3. Clients 0 and 1 hold requests continuously for 6 transactions:
//     grant order 0,1,0,1,0,1; exactly one rd_reqcyc pulse per transaction.
//  4. Change cl_addr[0] from 0x1000 to 0x2000 during WAIT:
//     rd_addr stays 0x1000 until COOL.
//  5. TIMEOUT=16, reader never responds:
//     err_timeout rises after 16 WAIT cycles and stays high; busy=1.
//     Assert reset: all outputs 0, and the next request issues normally.
//  6. rd_respcyc pulsed while IDLE:
//     no cl_respcyc, state unchanged.

Source files
------------

// File: rtl/muskbus_read_arbiter.sv
// ---------------------------------------------------------------------------
// muskbus_read_arbiter
//
// Shares one Muskbus cache-line reader (64-byte line, 512 bits) between NREQ
// clients, for example instruction fetch and data load. Arbitration is
// round-robin. Only one transaction is in flight at a time, and the grant is
// held from issue until the line comes back. Only the reader bids on Muskbus.
//
// Parameters
//   NREQ     number of requesting clients (>= 2)
//   TIMEOUT  limit on WAIT-state cycles before err_timeout is raised; 0 disables it
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   cl_reqcyc    per-client request, held high until that client's cl_respcyc
//   cl_addr      per-client line address, client i uses bits [i*64 +: 64]
//   cl_respcyc   one-cycle pulse to the granted client when the line is valid
//   cl_data      line data broadcast to all clients, valid only with cl_respcyc
//   rd_reqcyc    one-cycle start pulse to the reader
//   rd_addr      latched line address presented to the reader
//   rd_respcyc   reader line-complete pulse
//   rd_data      reader line data, valid with rd_respcyc
//   grant_id     index of the current or most recent grantee
//   busy         high whenever the arbiter is not idle
//   err_timeout  sticky flag: the reader did not answer within TIMEOUT cycles
// ---------------------------------------------------------------------------
module muskbus_read_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          cl_reqcyc,
  input  logic [NREQ*64-1:0]       cl_addr,
  output logic [NREQ-1:0]          cl_respcyc,
  output logic [511:0]             cl_data,
  output logic                     rd_reqcyc,
  output logic [63:0]              rd_addr,
  input  logic                     rd_respcyc,
  input  logic [511:0]             rd_data,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   rr_ptr_q;
  logic [GW-1:0]   grant_id_q;
  logic [63:0]     addr_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [CW-1:0]   wait_cnt_d;
  logic            err_timeout_q;

  logic            pick_valid;
  logic [GW-1:0]   pick_idx;
  logic            line_done;
  logic [GW-1:0]   next_ptr;

  // The scan runs from the farthest offset down to rr_ptr itself, so the
  // request nearest to rr_ptr (in round-robin order) is the last one written
  // and therefore wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cl_reqcyc[(int'(rr_ptr_q) + k) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // The wait counter saturates. Its width can hold TIMEOUT, so the timeout
  // comparison can still be reached.
  assign wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;

  assign line_done = (state_q == WAIT) && rd_respcyc;
  assign next_ptr  = (grant_id_q == GW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

  // The whole controller lives in one registered block: state, round-robin
  // pointer, grant, latched address, wait counter and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      addr_q        <= '0;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_id_q <= pick_idx;
            addr_q     <= cl_addr[int'(pick_idx) * 64 +: 64];
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_d;
          if (TIMEOUT != 0 && int'(wait_cnt_d) >= TIMEOUT) begin
            err_timeout_q <= 1'b1;
          end
          if (rd_respcyc) begin
            rr_ptr_q <= next_ptr;
            state_q  <= COOL;
          end
        end
        COOL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state. They are also forced low while
  // reset is asserted, so they read zero in the reset cycle itself and not only
  // after the reset edge.
  always_comb begin
    cl_respcyc = '0;
    cl_data    = '0;
    if (line_done && !reset) begin
      cl_respcyc[grant_id_q] = 1'b1;
      cl_data                = rd_data;
    end
  end

  assign rd_reqcyc   = !reset && (state_q == ISSUE);
  assign rd_addr     = reset ? '0 : addr_q;
  assign grant_id    = reset ? '0 : grant_id_q;
  assign busy        = !reset && (state_q != IDLE);
  assign err_timeout = !reset && err_timeout_q;

endmodule

// File: tb/tb_muskbus_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_muskbus_read_arbiter
//
// Directed testbench for muskbus_read_arbiter. One instance uses the default
// timeout and covers arbitration, data pass-through and address latching. A
// second instance with TIMEOUT=16 covers the timeout flag and reset recovery.
// ---------------------------------------------------------------------------
module tb_muskbus_read_arbiter;

  logic           clk = 1'b0;

  logic           reset;
  logic [1:0]     clReqcyc;
  logic [127:0]   clAddr;
  logic [1:0]     clRespcyc;
  logic [511:0]   clData;
  logic           rdReqcyc;
  logic [63:0]    rdAddr;
  logic           rdRespcyc;
  logic [511:0]   rdData;
  logic           grantId;
  logic           busy;
  logic           errTimeout;

  logic           tReset;
  logic [1:0]     tClReqcyc;
  logic [127:0]   tClAddr;
  logic [1:0]     tClRespcyc;
  logic [511:0]   tClData;
  logic           tRdReqcyc;
  logic [63:0]    tRdAddr;
  logic           tRdRespcyc;
  logic [511:0]   tRdData;
  logic           tGrantId;
  logic           tBusy;
  logic           tErrTimeout;

  int assertCount = 0;
  int failCount   = 0;

  // 10 ns clock shared by both instances.
  always #5 clk = ~clk;

  muskbus_read_arbiter #(.NREQ(2), .TIMEOUT(4096)) dut (
    .clk(clk), .reset(reset),
    .cl_reqcyc(clReqcyc), .cl_addr(clAddr),
    .cl_respcyc(clRespcyc), .cl_data(clData),
    .rd_reqcyc(rdReqcyc), .rd_addr(rdAddr),
    .rd_respcyc(rdRespcyc), .rd_data(rdData),
    .grant_id(grantId), .busy(busy), .err_timeout(errTimeout)
  );

  muskbus_read_arbiter #(.NREQ(2), .TIMEOUT(16)) dutTimeout (
    .clk(clk), .reset(tReset),
    .cl_reqcyc(tClReqcyc), .cl_addr(tClAddr),
    .cl_respcyc(tClRespcyc), .cl_data(tClData),
    .rd_reqcyc(tRdReqcyc), .rd_addr(tRdAddr),
    .rd_respcyc(tRdRespcyc), .rd_data(tRdData),
    .grant_id(tGrantId), .busy(tBusy), .err_timeout(tErrTimeout)
  );

  // Every comparison goes through this task. It counts the comparison and
  // reports a mismatch.
  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advances one clock. Sampling and driving happen 1 ns after the rising
  // edge, away from the active edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives the request inputs of the main instance.
  task automatic applyStimulus(input logic [1:0] req, input logic [63:0] a0,
                               input logic [63:0] a1);
    clReqcyc      = req;
    clAddr[63:0]  = a0;
    clAddr[127:64] = a1;
  endtask

  // Holds the main instance in reset for two cycles, then releases it with no
  // requests pending.
  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2'b00, 64'h0, 64'h0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
  endtask

  // Runs one full transaction on the main instance. On entry the arbiter must
  // be idle with requests already applied. The task steps through
  // ISSUE -> WAIT (readerCycles cycles) -> COOL -> IDLE and checks each phase.
  // Requests in dropMask are released in COOL.
  task automatic runTxn(input int expGrant, input logic [63:0] expAddr,
                        input int readerCycles, input logic [511:0] lineData,
                        input logic [1:0] dropMask);
    int stray;
    stray = 0;
    stepCycle();
    checkOutput("issue rd_reqcyc", rdReqcyc, 1'b1);
    checkOutput("issue grant_id", grantId, expGrant);
    checkOutput("issue rd_addr", rdAddr, expAddr);
    checkOutput("issue busy", busy, 1'b1);
    stepCycle();
    for (int i = 1; i < readerCycles; i++) begin
      if (rdReqcyc !== 1'b0 || clRespcyc !== 2'b00 || rdAddr !== expAddr) stray++;
      stepCycle();
    end
    if (rdReqcyc !== 1'b0) stray++;
    checkOutput("wait quiet", stray, 0);
    rdRespcyc = 1'b1;
    rdData    = lineData;
    #1;
    checkOutput("resp cl_respcyc", clRespcyc, 2'b01 << expGrant);
    checkOutput("resp cl_data", clData, lineData);
    stepCycle();
    rdRespcyc = 1'b0;
    rdData    = '0;
    clReqcyc  = clReqcyc & ~dropMask;
    #1;
    checkOutput("cool outputs", {clRespcyc, rdReqcyc, busy}, 4'b0001);
    checkOutput("cool cl_data", clData, 512'h0);
    stepCycle();
    checkOutput("idle busy", busy, 1'b0);
  endtask

  int expOrder[6]   = '{0, 1, 0, 1, 0, 1};
  int readerLen[6]  = '{2, 5, 1, 3, 4, 2};

  // Main sequence: the directed scenarios run in order on the two instances.
  initial begin
    int stray;
    $display("[TB] starting muskbus_read_arbiter bench");
    reset      = 1'b1;
    tReset     = 1'b1;
    clReqcyc   = '0;
    clAddr     = '0;
    rdRespcyc  = 1'b0;
    rdData     = '0;
    tClReqcyc  = '0;
    tClAddr    = '0;
    tRdRespcyc = 1'b0;
    tRdData    = '0;

    // Reset state: all outputs are zero.
    stepCycle();
    stepCycle();
    checkOutput("reset outputs",
                {clRespcyc, rdReqcyc, grantId, busy, errTimeout}, 6'b0);
    checkOutput("reset rd_addr", rdAddr, 64'h0);
    checkOutput("reset cl_data", clData, 512'h0);
    reset = 1'b0;

    // Scenario 1: client 0 alone, address 0x1000, reader answers after 20 cycles.
    applyStimulus(2'b01, 64'h1000, 64'h0);
    runTxn(0, 64'h1000, 20, {8{64'hDEAD_BEEF_0123_4567}}, 2'b01);
    checkOutput("s1 no timeout", errTimeout, 1'b0);

    // Scenario 2: both clients request together right after reset.
    doReset();
    applyStimulus(2'b11, 64'hA000, 64'hB000);
    runTxn(0, 64'hA000, 3, {16{32'hAAAA_0001}}, 2'b01);
    runTxn(1, 64'hB000, 3, {16{32'hBBBB_0002}}, 2'b10);

    // Scenario 3: both clients hold their requests for six transactions.
    doReset();
    applyStimulus(2'b11, 64'hC000, 64'hD000);
    for (int i = 0; i < 6; i++) begin
      runTxn(expOrder[i], (expOrder[i] != 0) ? 64'hD000 : 64'hC000,
             readerLen[i], {16{32'h5A00_0000 + 32'(i)}}, 2'b00);
    end
    clReqcyc = 2'b00;

    // Scenario 4: cl_addr changes during WAIT and the client drops its request.
    // The latched address and the delivery must both survive.
    applyStimulus(2'b01, 64'h1000, 64'h0);
    stepCycle();
    checkOutput("s4 issue addr", rdAddr, 64'h1000);
    stepCycle();
    applyStimulus(2'b00, 64'h2000, 64'h0);
    #1;
    checkOutput("s4 wait addr", rdAddr, 64'h1000);
    stepCycle();
    stepCycle();
    checkOutput("s4 late wait addr", rdAddr, 64'h1000);
    rdRespcyc = 1'b1;
    rdData    = {8{64'h0F0F_F0F0_1234_5678}};
    #1;
    checkOutput("s4 dropped still served", clRespcyc, 2'b01);
    stepCycle();
    rdRespcyc = 1'b0;
    rdData    = '0;
    checkOutput("s4 cool addr", rdAddr, 64'h1000);
    stepCycle();

    // Scenario 6: a reader pulse while idle is ignored.
    rdRespcyc = 1'b1;
    rdData    = {16{32'hFFFF_0000}};
    #1;
    checkOutput("s6 idle resp", clRespcyc, 2'b00);
    checkOutput("s6 idle data", clData, 512'h0);
    stepCycle();
    rdRespcyc = 1'b0;
    rdData    = '0;
    checkOutput("s6 stays idle", {busy, rdReqcyc}, 2'b00);

    // Reset in the middle of a transaction clears everything immediately,
    // and the next request then issues normally.
    applyStimulus(2'b10, 64'h0, 64'hE000);
    stepCycle();
    stepCycle();
    reset = 1'b1;
    #1;
    checkOutput("midreset outputs", {clRespcyc, rdReqcyc, busy}, 4'b0);
    stepCycle();
    reset = 1'b0;
    applyStimulus(2'b00, 64'h0, 64'h0);
    stepCycle();
    checkOutput("midreset idle", busy, 1'b0);
    applyStimulus(2'b01, 64'hF000, 64'h0);
    runTxn(0, 64'hF000, 2, {8{64'h1111_2222_3333_4444}}, 2'b01);

    // Scenario 5: TIMEOUT=16 and the reader never answers.
    tReset = 1'b0;
    tClReqcyc = 2'b01;
    tClAddr[63:0] = 64'h3000;
    stepCycle();
    checkOutput("s5 issue", {tRdReqcyc, tBusy}, 2'b11);
    checkOutput("s5 issue addr", tRdAddr, 64'h3000);
    stepCycle();
    stray = 0;
    for (int i = 2; i <= 16; i++) begin
      if (tErrTimeout !== 1'b0) stray++;
      stepCycle();
    end
    checkOutput("s5 err before limit", tErrTimeout | (stray != 0), 1'b0);
    stepCycle();
    checkOutput("s5 err at limit", tErrTimeout, 1'b1);
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("s5 err sticky busy", {tErrTimeout, tBusy}, 2'b11);
    tReset    = 1'b1;
    tClReqcyc = 2'b00;
    #1;
    checkOutput("s5 during reset", {tErrTimeout, tBusy, tRdReqcyc, tClRespcyc}, 5'b0);
    stepCycle();
    checkOutput("s5 after reset", {tErrTimeout, tBusy, tGrantId}, 3'b0);
    checkOutput("s5 after reset addr", tRdAddr, 64'h0);
    tReset = 1'b0;
    tClReqcyc = 2'b10;
    tClAddr[127:64] = 64'h4000;
    stepCycle();
    checkOutput("s5 reissue", {tRdReqcyc, tGrantId}, 2'b11);
    checkOutput("s5 reissue addr", tRdAddr, 64'h4000);
    stepCycle();
    tRdRespcyc = 1'b1;
    tRdData    = {8{64'hCAFE_F00D_0000_0005}};
    #1;
    checkOutput("s5 reissue resp", tClRespcyc, 2'b10);
    checkOutput("s5 reissue data", tClData, {8{64'hCAFE_F00D_0000_0005}});
    stepCycle();
    tRdRespcyc = 1'b0;
    tClReqcyc  = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
